// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one shared full-adder bit slice, LSB first, one bit per clock.
// Optional feature: define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_s, fa_co, last_bit;

  // Shared 1-bit full adder slice.
  always_comb begin
    fa_s  = a_q[0] ^ b_q[0] ^ carry_q;
    fa_co = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  end

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_co;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        if (last_bit) begin
          // Result is loaded on the edge into DONE so sum/cout are valid while done is high.
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_co;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = carry_q ^ fa_co;
`endif
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8); checks ovf too when SERIAL_ADD_OVF_EN is defined.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;
  logic         ovf;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

`ifndef SERIAL_ADD_OVF_EN
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_m;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned ndone   = 0;
  int unsigned last_done_cyc = 0;
  int unsigned blen    = 0;
  logic        done_prev = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    exp_t         r;
    logic [W:0]   t;
    logic [W-1:0] lo;
    t   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    lo  = {1'b0, x[W-2:0]} + {1'b0, y[W-2:0]} + {{(W-1){1'b0}}, ci};
    r.s = t[W-1:0];
    r.c = t[W];
    r.v = lo[W-1] ^ t[W];
    return r;
  endfunction

  // Output monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      blen      = 0;
      done_prev = 1'b0;
    end else begin
      if (busy || done) check("busy_done_excl", busy & done, 0);
      if (busy) blen++;
      else if (blen != 0) begin
        check("busy_len", blen, W);
        blen = 0;
      end
      if (done) begin
        check("done_width", done_prev, 0);
        check("spurious_done", sb.size() == 0, 0);
        if (sb.size() != 0) begin
          e_m = sb.pop_front();
          check("sum", sum, e_m.s);
          check("cout", cout, e_m.c);
`ifdef SERIAL_ADD_OVF_EN
          check("ovf", ovf, e_m.v);
`endif
        end
        ndone++;
        last_done_cyc = cyc;
      end
      done_prev = done;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      if (!busy && !done) return;
      tick();
    end
    check("idle_timeout", {busy, done}, 0);
  endtask

  task automatic wait_ndone(input int unsigned target, input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      if (ndone >= target) return;
      tick();
    end
    check("done_timeout", ndone, target);
  endtask

  task automatic drive_start(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    wait_idle();
    a     = x;
    b     = y;
    cin   = ci;
    start = 1'b1;
    sb.push_back(model(x, y, ci));
    tick();
    start = 1'b0;
  endtask

  task automatic do_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    int unsigned n0;
    n0 = ndone;
    drive_start(x, y, ci);
    wait_ndone(n0 + 1, 20);
  endtask

  initial begin
    int unsigned n0, c0, t0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    tick();

    // FF + 01: carry ripples through all bits; latency check
    wait_idle();
    c0 = cyc;
    n0 = ndone;
    drive_start(8'hFF, 8'h01, 1'b0);
    wait_ndone(n0 + 1, 20);
    check("latency", last_done_cyc - c0, 9);

    // 5A + 33 + 1 with an ignored start mid-add
    n0 = ndone;
    drive_start(8'h5A, 8'h33, 1'b1);
    check("sum_hold", sum, 8'h00);
    check("cout_hold", cout, 1);
    tick();
    tick();
    start = 1'b1;
    a     = 8'h01;
    b     = 8'h01;
    cin   = 1'b0;
    tick();
    start = 1'b0;
    wait_ndone(n0 + 1, 20);
    repeat (12) tick();
    check("ignored_start", ndone, n0 + 1);

    // Reset in busy cycle 4 aborts the add
    drive_start(8'h12, 8'h34, 1'b0);
    repeat (3) tick();
    check("pre_rst_busy", busy, 1);
    n0    = ndone;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_sum", sum, 0);
    check("arst_cout", cout, 0);
    check("arst_ovf", ovf, 0);
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (15) tick();
    check("rst_no_done", ndone, n0);
    do_add(8'h12, 8'h34, 1'b1);

    // Back-to-back with start held high: one add per WIDTH+2 cycles
    wait_idle();
    n0 = ndone;
    repeat (3) sb.push_back(model(8'h7F, 8'h01, 1'b0));
    a     = 8'h7F;
    b     = 8'h01;
    cin   = 1'b0;
    start = 1'b1;
    wait_ndone(n0 + 1, 20);
    t0 = last_done_cyc;
    for (int unsigned k = 2; k <= 3; k++) begin
      wait_ndone(n0 + k, 20);
      check("b2b_period", last_done_cyc - t0, W + 2);
      t0 = last_done_cyc;
    end
    start = 1'b0;
    repeat (12) tick();
    check("b2b_count", ndone, n0 + 3);

    // Random adds
    for (int i = 0; i < 1000; i++) begin
      do_add(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end

    repeat (5) tick();
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
